// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sched
//  Description : Window sequencer for the 7x7 convolution core. Walks the
//                kernel window in raster order over the configured map,
//                issues one core enable per position, tracks results in
//                flight and buffers them in a FIFO toward a valid/ready sink.
//                Issue is credit-gated so the FIFO can never overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_sched #(
  parameter int K     = 7,
  parameter int LAT   = 10,   // must be >= 2 (tag shift register)
  parameter int DEPTH = 16,   // power of 2
  parameter int DIM_W = 8,
  parameter int OUT_W = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [DIM_W-1:0] i_cfg_width,
  input  logic [DIM_W-1:0] i_cfg_height,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_core_en,
  output logic [DIM_W-1:0] o_win_row,
  output logic [DIM_W-1:0] o_win_col,
  input  logic             i_core_valid,
  input  logic [OUT_W-1:0] i_core_out,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last
);

  localparam int               c_aw    = $clog2(DEPTH);
  localparam logic [DIM_W-1:0] c_k     = DIM_W'(K);
  localparam logic [c_aw:0]    c_one   = (c_aw+1)'(1);
  localparam logic [c_aw+1:0]  c_depth = (c_aw+2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_h;
  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_col;
  logic             r_err;
  logic [c_aw:0]    r_inflight;
  logic [c_aw:0]    r_wptr;
  logic [c_aw:0]    r_rptr;
  logic [LAT-1:0]   r_tag;
  logic [OUT_W:0]   r_mem [DEPTH];

  logic [c_aw:0]    w_count;
  logic [c_aw+1:0]  w_sum;
  logic             w_empty;
  logic             w_issue;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_last_pos;
  logic             w_cfg_bad;
  logic             w_pop;
  logic [OUT_W:0]   w_head;

  // FIFO occupancy plus results still inside the core pipeline form the credit
  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (w_count == '0);
  assign w_sum      = {1'b0, w_count} + {1'b0, r_inflight};
  assign w_issue    = (r_state == S_RUN) && (w_sum < c_depth);
  assign w_col_end  = (r_col == (r_w - c_k));
  assign w_row_end  = (r_row == (r_h - c_k));
  assign w_last_pos = w_col_end && w_row_end;
  assign w_cfg_bad  = (i_cfg_width < c_k) || (i_cfg_height < c_k);
  assign w_pop      = !w_empty && i_out_ready;
  assign w_head     = r_mem[r_rptr[c_aw-1:0]];

  assign o_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_DONE) && r_err;
  assign o_core_en   = w_issue;
  assign o_win_row   = w_issue ? r_row : '0;
  assign o_win_col   = w_issue ? r_col : '0;
  assign o_out_valid = !w_empty;
  assign o_out_data  = w_empty ? '0 : w_head[OUT_W-1:0];
  assign o_out_last  = !w_empty && w_head[OUT_W];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: bad dimensions skip straight to DONE with err armed
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = w_cfg_bad ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && w_last_pos) w_next = S_DRAIN;
      S_DRAIN: if ((r_inflight == '0) && w_empty) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Config capture on start and raster walk of the window position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w   <= '0;
      r_h   <= '0;
      r_row <= '0;
      r_col <= '0;
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_w   <= i_cfg_width;
      r_h   <= i_cfg_height;
      r_row <= '0;
      r_col <= '0;
      r_err <= w_cfg_bad;
    end else if (w_issue) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Results in flight: up on issue, down on core_valid, hold when both
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_inflight <= '0;
    else if (w_issue && !i_core_valid)   r_inflight <= r_inflight + c_one;
    else if (!w_issue && i_core_valid)   r_inflight <= r_inflight - c_one;
  end

  // Last-of-frame flag travels alongside the core pipeline, aligned to core_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tag <= '0;
    else     r_tag <= {r_tag[LAT-2:0], w_issue && w_last_pos};
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_core_valid) r_wptr <= r_wptr + c_one;
      if (w_pop)        r_rptr <= r_rptr + c_one;
    end
  end

  // FIFO storage: result with its last flag in the MSB
  always_ff @(posedge clk) begin
    if (i_core_valid) r_mem[r_wptr[c_aw-1:0]] <= {r_tag[LAT-1], i_core_out};
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_sched
//  Description : Directed self-checking bench for conv_sched with a simple
//                fixed-latency core model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_sched;
  localparam int K = 7, LAT = 10, DEPTH = 16, DIM_W = 8, OUT_W = 39;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DIM_W-1:0] cfg_w, cfg_h;
  logic             busy, done, err, core_en;
  logic [DIM_W-1:0] win_row, win_col;
  logic             core_valid;
  logic [OUT_W-1:0] core_out;
  logic [OUT_W-1:0] out_data;
  logic             out_valid, out_ready, out_last;

  conv_sched #(.K(K), .LAT(LAT), .DEPTH(DEPTH), .DIM_W(DIM_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_cfg_width(cfg_w), .i_cfg_height(cfg_h),
    .o_busy(busy), .o_done(done), .o_err(err), .o_core_en(core_en),
    .o_win_row(win_row), .o_win_col(win_col), .i_core_valid(core_valid),
    .i_core_out(core_out), .o_out_data(out_data), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_last(out_last)
  );

  always #5 clk = ~clk;

  // Core model: fixed LAT-cycle pipeline, result tagged with its window position
  logic [LAT-1:0]   pipe_v;
  logic [OUT_W-1:0] pipe_d [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], core_en};
      pipe_d[0] <= {23'h12345, win_row, win_col};
      for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign core_valid = pipe_v[LAT-1];
  assign core_out   = pipe_d[LAT-1];

  function automatic logic [OUT_W-1:0] exp_data(input int r, input int c);
    return {23'h12345, r[7:0], c[7:0]};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge
  int         iss_r[$], iss_c[$], iss_cyc[$], res_cyc[$];
  logic [OUT_W-1:0] res_d[$];
  bit         res_l[$];
  int         first_valid_cyc, n_done, done_cyc, n_err, err_cyc, n_busy;
  int         occ = 0, max_occ, n_ovf;
  always @(negedge clk) begin
    if (rst) begin
      occ = 0;
    end else begin
      if (core_en) begin
        iss_r.push_back(int'(win_row));
        iss_c.push_back(int'(win_col));
        iss_cyc.push_back(cyc);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        res_d.push_back(out_data);
        res_l.push_back(out_last);
        res_cyc.push_back(cyc);
      end
      if (core_valid && occ == DEPTH && !(out_valid && out_ready)) n_ovf++;
      occ = occ + (core_valid ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
      if (done) begin n_done++; done_cyc = cyc; end
      if (err)  begin n_err++;  err_cyc  = cyc; end
      if (busy) n_busy++;
    end
  end

  int n_cmp = 0, n_fail = 0;
  int start_cyc;

  task automatic clear_mon();
    iss_r.delete(); iss_c.delete(); iss_cyc.delete();
    res_d.delete(); res_l.delete(); res_cyc.delete();
    first_valid_cyc = -1; n_done = 0; done_cyc = -1; n_err = 0; err_cyc = -1;
    n_busy = 0; max_occ = 0; n_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input int w, input int h);
    start = 1'b1; cfg_w = w[7:0]; cfg_h = h[7:0]; start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_w = '0; cfg_h = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if ({busy, done, err, core_en} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, err, core_en}); end
    n_cmp++; if ({win_row, win_col} !== 16'h0) begin n_fail++; $display("FAIL reset_win: got %h want 0000", {win_row, win_col}); end
    n_cmp++; if ({out_valid, out_last} !== 2'b0) begin n_fail++; $display("FAIL reset_out: got %b want 00", {out_valid, out_last}); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    rst = 1'b0;
    clear_mon();
    repeat (3) tick();
    n_cmp++; if (iss_r.size() != 0 || n_busy != 0) begin n_fail++; $display("FAIL idle_no_start: issues %0d busy %0d want 0 0", iss_r.size(), n_busy); end
  endtask

  task automatic test_single();
    bit ok;
    clear_mon();
    start_frame(7, 7);
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_done: timeout"); end
    n_cmp++; if (iss_r.size() != 1) begin n_fail++; $display("FAIL single_issues: got %0d want 1", iss_r.size()); end
    if (iss_r.size() >= 1) begin
      n_cmp++; if (iss_r[0] != 0 || iss_c[0] != 0) begin n_fail++; $display("FAIL single_pos: got (%0d,%0d) want (0,0)", iss_r[0], iss_c[0]); end
      n_cmp++; if (first_valid_cyc - iss_cyc[0] != LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", first_valid_cyc - iss_cyc[0], LAT + 1); end
    end
    n_cmp++; if (res_d.size() != 1) begin n_fail++; $display("FAIL single_results: got %0d want 1", res_d.size()); end
    if (res_d.size() >= 1) begin
      n_cmp++; if (res_d[0] !== exp_data(0, 0) || res_l[0] !== 1'b1) begin n_fail++; $display("FAIL single_data: got %h/%0d want %h/1", res_d[0], res_l[0], exp_data(0, 0)); end
      n_cmp++; if (!(done_cyc > res_cyc[0] && done_cyc <= res_cyc[0] + 3)) begin n_fail++; $display("FAIL single_done_after_pop: done %0d pop %0d", done_cyc, res_cyc[0]); end
    end
    n_cmp++; if (n_err != 0) begin n_fail++; $display("FAIL single_err: got %0d want 0", n_err); end
  endtask

  // Shared by the 9x8 frame and the ignored-restart frame
  task automatic test_frame_9x8(input bit restart_mid);
    bit ok;
    int bad_pos, bad_res;
    clear_mon();
    start_frame(9, 8);
    if (restart_mid) begin
      tick();
      start = 1'b1; cfg_w = 8'd12; cfg_h = 8'd12;
      tick();
      start = 1'b0;
    end
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL f9x8_done(r=%0d): timeout", restart_mid); end
    n_cmp++; if (iss_r.size() != 6) begin n_fail++; $display("FAIL f9x8_issues(r=%0d): got %0d want 6", restart_mid, iss_r.size()); end
    n_cmp++; if (res_d.size() != 6) begin n_fail++; $display("FAIL f9x8_results(r=%0d): got %0d want 6", restart_mid, res_d.size()); end
    n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL f9x8_done_count(r=%0d): got %0d want 1", restart_mid, n_done); end
    if (iss_r.size() == 6 && res_d.size() == 6) begin
      bad_pos = 0; bad_res = 0;
      for (int i = 0; i < 6; i++) begin
        if (iss_r[i] != i / 3 || iss_c[i] != i % 3) bad_pos++;
        if (res_d[i] !== exp_data(i / 3, i % 3) || res_l[i] !== (i == 5)) bad_res++;
      end
      n_cmp++; if (bad_pos != 0) begin n_fail++; $display("FAIL f9x8_coords(r=%0d): got %0d wrong want 0", restart_mid, bad_pos); end
      n_cmp++; if (bad_res != 0) begin n_fail++; $display("FAIL f9x8_order_last(r=%0d): got %0d wrong want 0", restart_mid, bad_res); end
      n_cmp++; if (iss_cyc[5] - iss_cyc[0] != 5) begin n_fail++; $display("FAIL f9x8_b2b(r=%0d): got span %0d want 5", restart_mid, iss_cyc[5] - iss_cyc[0]); end
    end
  endtask

  task automatic test_backpressure(input int dim);
    bit ok;
    int total, per_row, bad;
    per_row = dim - K + 1;
    total   = per_row * per_row;
    clear_mon();
    out_ready = 1'b0;
    start_frame(dim, dim);
    repeat (60) tick();
    n_cmp++; if (iss_r.size() != DEPTH) begin n_fail++; $display("FAIL bp%0d_stall_issues: got %0d want %0d", dim, iss_r.size(), DEPTH); end
    n_cmp++; if (core_en !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_stalled: core_en %b out_valid %b want 0 1", dim, core_en, out_valid); end
    n_cmp++; if (max_occ != DEPTH) begin n_fail++; $display("FAIL bp%0d_fill: got %0d want %0d", dim, max_occ, DEPTH); end
    out_ready = 1'b1;
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp%0d_done: timeout", dim); end
    n_cmp++; if (iss_r.size() != total || res_d.size() != total) begin n_fail++; $display("FAIL bp%0d_counts: got %0d/%0d want %0d", dim, iss_r.size(), res_d.size(), total); end
    if (res_d.size() == total) begin
      bad = 0;
      for (int i = 0; i < total; i++)
        if (res_d[i] !== exp_data(i / per_row, i % per_row) || res_l[i] !== (i == total - 1)) bad++;
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp%0d_order: got %0d wrong want 0", dim, bad); end
    end
    n_cmp++; if (n_ovf != 0 || max_occ > DEPTH) begin n_fail++; $display("FAIL bp%0d_overflow: got %0d pushes-when-full, max %0d", dim, n_ovf, max_occ); end
  endtask

  task automatic test_bad_dims(input int w, input int h);
    clear_mon();
    start_frame(w, h);
    repeat (6) tick();
    n_cmp++; if (n_done != 1 || n_err != 1 || err_cyc != done_cyc) begin n_fail++; $display("FAIL bad%0dx%0d_pulse: done %0d err %0d cycles %0d/%0d want 1 1 equal", w, h, n_done, n_err, done_cyc, err_cyc); end
    n_cmp++; if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin n_fail++; $display("FAIL bad%0dx%0d_latency: got %0d want 1..2", w, h, done_cyc - start_cyc); end
    n_cmp++; if (iss_r.size() != 0 || n_busy != 0) begin n_fail++; $display("FAIL bad%0dx%0d_quiet: issues %0d busy %0d want 0 0", w, h, iss_r.size(), n_busy); end
  endtask

  task automatic test_reset_mid();
    bit ok, reached;
    clear_mon();
    start_frame(12, 12);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (iss_r.size() >= 20) begin reached = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!reached) begin n_fail++; $display("FAIL rstmid_reach20: got %0d issues want 20", iss_r.size()); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, done, err, core_en, out_valid, out_last} !== 6'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 000000", {busy, done, err, core_en, out_valid, out_last}); end
    n_cmp++; if ({win_row, win_col} !== 16'h0 || out_data !== '0) begin n_fail++; $display("FAIL rstmid_data: win %h data %h want 0", {win_row, win_col}, out_data); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
    clear_mon();
    start_frame(7, 7);
    wait_done(200, ok);
    n_cmp++; if (!ok || iss_r.size() != 1 || res_d.size() != 1) begin n_fail++; $display("FAIL rstmid_restart: done %0d issues %0d results %0d want 1 1 1", ok, iss_r.size(), res_d.size()); end
    if (res_d.size() == 1) begin
      n_cmp++; if (res_d[0] !== exp_data(0, 0) || res_l[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_result: got %h/%0d want %h/1", res_d[0], res_l[0], exp_data(0, 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_9x8(1'b0);
    test_backpressure(10);
    test_backpressure(12);
    test_bad_dims(6, 20);
    test_bad_dims(20, 6);
    test_reset_mid();
    test_frame_9x8(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Sequencer for the 49-tap (7x7) fixed-point convolution core.
- Walks a 7x7 window in raster order across a configured input map (stride 1, no padding).
- Issues one core enable per window position and tracks results in flight through the fixed-latency core pipeline.
- Buffers core results in a small FIFO and hands them downstream on a valid/ready interface, throttling issue with a credit check so no result is ever dropped.

Parameters:
K, 7, kernel edge; window count per axis = dim-K+1
LAT, 10, core latency from enable to valid (cycles)
DEPTH, 16, result FIFO depth (power of 2)
DIM_W, 8, width of dimension/coordinate fields
OUT_W, 39, core result width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
cfg_width  in  DIM_W  input map width, sampled with start
cfg_height  in  DIM_W  input map height, sampled with start
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at frame end
err  out  1  one-cycle pulse, coincident with done, when a dimension is < K
core_en  out  1  enable to core, one cycle per window
win_row  out  DIM_W  top-left row of the issued window, valid with core_en
win_col  out  DIM_W  top-left column of the issued window, valid with core_en
core_valid  in  1  result strobe from core
core_out  in  OUT_W  core result
out_data  out  OUT_W  FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accept
out_last  out  1  head entry is the final result of the frame

Behaviour:
- Reset: all outputs 0; state IDLE; counters, FIFO pointers, tag shift register and inflight cleared.
- FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches cfg.
  - If cfg_width<K or cfg_height<K: go to DONE with err armed, no issue.
  - Otherwise go to RUN with row=col=0.
  - start while not IDLE is ignored.
- RUN:
  - Issue (core_en=1) when fifo_count + inflight < DEPTH.
  - win_row/win_col hold the current position registered with core_en; both read 0 when core_en=0.
  - After an issue, col increments. When col == cfg_width-K, col wraps to 0 and row increments.
  - Issue of position (cfg_height-K, cfg_width-K) moves the FSM to DRAIN.
- DRAIN: no issue. Move to DONE when inflight==0 and the FIFO is empty (last result popped).
- DONE: done=1 (and err=1 if armed) for one cycle; busy=0; return to IDLE. First possible restart is the cycle after DONE.
- inflight:
  - +1 on issue, -1 on core_valid; both in the same cycle leaves it unchanged.
  - Range 0..DEPTH.
- Last tag: a LAT-deep shift register carries a last flag alongside core_en. The flag is written into the FIFO with core_out on core_valid and appears as out_last at the FIFO head.
- FIFO:
  - Push on core_valid; pop on out_valid && out_ready. Simultaneous push and pop is legal at any occupancy.
  - A push when full cannot occur by construction, given the credit rule. Verification asserts this.
  - out_data/out_last are undefined when out_valid=0.
- Throughput: one issue per cycle with no backpressure. The first result is valid at the FIFO head LAT+1 cycles after its core_en.
- Results leave in the order issued; raster order and count = (W-K+1)*(H-K+1).
- rst asserted mid-frame: immediate return to IDLE, FIFO emptied, no done pulse. The core is reset by the same reset.
- Arithmetic: core_out passes through unmodified (no rounding or saturation).

Test Plan:
- cfg 7x7, out_ready=1, start -> exactly one core_en with (0,0). Result appears LAT+1 cycles later with out_last=1; done pulses after the pop; err=0.
- cfg width 9, height 8, out_ready=1 -> 6 consecutive core_en cycles at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). 6 results in order; out_last only on the 6th.
- cfg 10x10, out_ready=0 -> exactly 16 core_en pulses, then core_en stays low. Raising out_ready gives one issue per pop, 16 results total; no FIFO overflow assertion fires.
- cfg width 6, height 20 -> done=err=1 pulse within 2 cycles of start; zero core_en; busy never high.
- cfg 12x12; rst pulsed after 20 issues -> all outputs 0 the same cycle. A new start with 7x7 completes normally with 1 result.
- start pulsed again during RUN with different cfg -> ignored; the original frame's count and coordinates are unchanged.
